// File: rtl/buf_cmd_if.sv
// ---------------------------------------------------------------------------
// buf_cmd_if
// Bundles the three buses of the buffer command controller:
//   req_*  : upstream request channel (valid/ready), carries op, mode, data
//   buf_*  : single-cycle command port to the shared FIFO/LIFO buffer, plus
//            the buffer's registered pop data and full/empty flags
//   rsp_*  : response channel (valid/ready), carries popped data and errors
// Modports:
//   slave  : the controller's view (accepts requests, drives the buffer,
//            produces responses)
//   master : the environment's view (requester, buffer, response consumer)
// ---------------------------------------------------------------------------
interface buf_cmd_if #(
    parameter int DinLENGTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [1:0]           req_mode;
    logic [DinLENGTH-1:0] req_data;

    logic [1:0]           buf_mode;
    logic [1:0]           buf_opcode;
    logic [DinLENGTH-1:0] buf_din;
    logic [DinLENGTH-1:0] buf_dout;
    logic                 buf_full;
    logic                 buf_empty;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DinLENGTH-1:0] rsp_data;
    logic [1:0]           rsp_err;

    modport slave (
        input  req_valid, req_op, req_mode, req_data,
        output req_ready,
        output buf_mode, buf_opcode, buf_din,
        input  buf_dout, buf_full, buf_empty,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_mode, req_data,
        input  req_ready,
        input  buf_mode, buf_opcode, buf_din,
        output buf_dout, buf_full, buf_empty,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/buf_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// buf_cmd_ctrl
// Upstream command controller for the shared FIFO/LIFO buffer. Takes one
// request at a time, turns it into one or two single-cycle buffer commands,
// refuses commands the buffer flags say are illegal, captures popped data and
// returns exactly one response per accepted request, in order.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (same net as the buffer reset)
//   bus    : buf_cmd_if.slave
//            req_valid/req_ready/req_op/req_mode/req_data  request channel
//            buf_mode/buf_opcode/buf_din                    buffer command
//            buf_dout/buf_full/buf_empty                    buffer status
//            rsp_valid/rsp_ready/rsp_data/rsp_err           response channel
//              rsp_err[0] = push refused (full), rsp_err[1] = pop refused
//
// Opcode encoding (req_op and buf_opcode): 00 NIMIC, 01 PUSH, 10 POP,
// 11 PUSH_POP. buf_opcode only ever carries NIMIC, PUSH or POP; a PUSH_POP
// request is split into a PUSH in ISSUE1 and a POP in ISSUE2.
// ---------------------------------------------------------------------------
module buf_cmd_ctrl #(
    parameter int DinLENGTH = 32,
    parameter int BUF_SIZE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    buf_cmd_if.slave   bus
);
    localparam logic [1:0] OP_NIMIC    = 2'b00;
    localparam logic [1:0] OP_PUSH     = 2'b01;
    localparam logic [1:0] OP_POP      = 2'b10;
    localparam logic [1:0] OP_PUSH_POP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        SETTLE1,
        ISSUE2,
        SETTLE2,
        RESP
    } state_t;

    state_t               state_reg,      state_next;
    logic [1:0]           op_reg,         op_next;
    logic                 popped_reg,     popped_next;
    logic                 req_ready_reg,  req_ready_next;
    logic [1:0]           buf_opcode_reg, buf_opcode_next;
    logic [1:0]           buf_mode_reg,   buf_mode_next;
    logic [DinLENGTH-1:0] buf_din_reg,    buf_din_next;
    logic                 rsp_valid_reg,  rsp_valid_next;
    logic [DinLENGTH-1:0] rsp_data_reg,   rsp_data_next;
    logic [1:0]           rsp_err_reg,    rsp_err_next;

    // Every output is a register, so the value shown in a state is decided
    // on the edge that enters it. The ISSUE1 command is therefore chosen
    // from the flags at the accept edge and the ISSUE2 command from the
    // flags at the end of SETTLE1; in both cases the last command was at
    // least one full cycle earlier, so the registered flags have settled.
    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        popped_next     = popped_reg;
        req_ready_next  = req_ready_reg;
        buf_opcode_next = OP_NIMIC;
        buf_mode_next   = buf_mode_reg;
        buf_din_next    = buf_din_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                // req_ready is low for the first IDLE cycle after reset,
                // so acceptance is qualified by the registered ready.
                if (req_ready_reg && bus.req_valid) begin
                    state_next     = ISSUE1;
                    req_ready_next = 1'b0;
                    op_next        = bus.req_op;
                    buf_mode_next  = bus.req_mode;
                    buf_din_next   = bus.req_data;
                    rsp_data_next  = '0;
                    rsp_err_next   = 2'b00;
                    popped_next    = 1'b0;
                    case (bus.req_op)
                        OP_PUSH, OP_PUSH_POP: begin
                            if (!bus.buf_full) buf_opcode_next = OP_PUSH;
                            else               rsp_err_next[0] = 1'b1;
                        end
                        OP_POP: begin
                            if (!bus.buf_empty) begin
                                buf_opcode_next = OP_POP;
                                popped_next     = 1'b1;
                            end else begin
                                rsp_err_next[1] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ISSUE1: state_next = SETTLE1;

            SETTLE1: begin
                // Buffer pop data is registered, valid during SETTLE1.
                if (popped_reg) rsp_data_next = bus.buf_dout;
                if (op_reg == OP_PUSH_POP) begin
                    state_next  = ISSUE2;
                    popped_next = 1'b0;
                    // The ISSUE1 push (if any) took effect on the edge that
                    // started SETTLE1, so buf_empty already reflects it.
                    if (!bus.buf_empty) begin
                        buf_opcode_next = OP_POP;
                        popped_next     = 1'b1;
                    end else begin
                        rsp_err_next[1] = 1'b1;
                    end
                end else begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                end
            end

            ISSUE2: state_next = SETTLE2;

            SETTLE2: begin
                if (popped_reg) rsp_data_next = bus.buf_dout;
                state_next     = RESP;
                rsp_valid_next = 1'b1;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            op_reg         <= OP_NIMIC;
            popped_reg     <= 1'b0;
            req_ready_reg  <= 1'b0;
            buf_opcode_reg <= OP_NIMIC;
            buf_mode_reg   <= 2'b00;
            buf_din_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 2'b00;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            popped_reg     <= popped_next;
            req_ready_reg  <= req_ready_next;
            buf_opcode_reg <= buf_opcode_next;
            buf_mode_reg   <= buf_mode_next;
            buf_din_reg    <= buf_din_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.buf_opcode = buf_opcode_reg;
    assign bus.buf_mode   = buf_mode_reg;
    assign bus.buf_din    = buf_din_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_err    = rsp_err_reg;

    // Shadow occupancy of the buffer as implied by the commands we issued.
    // Modes 10/11 are no-ops in the buffer, so they do not move the count.
    // Only the assertions below read it.
    localparam int               OCC_W   = $clog2(BUF_SIZE + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(BUF_SIZE);

    logic [OCC_W-1:0] occ_reg;
    logic [1:0]       prev_opcode_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_reg         <= '0;
            prev_opcode_reg <= OP_NIMIC;
        end else begin
            prev_opcode_reg <= buf_opcode_reg;
            if (!buf_mode_reg[1]) begin
                if (buf_opcode_reg == OP_PUSH)     occ_reg <= occ_reg + OCC_W'(1);
                else if (buf_opcode_reg == OP_POP) occ_reg <= occ_reg - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (occ_reg <= OCC_MAX);
            assert (bus.buf_full == (occ_reg == OCC_MAX));
            assert (bus.buf_empty == (occ_reg == '0));
            assert (!(buf_opcode_reg != OP_NIMIC && prev_opcode_reg != OP_NIMIC));
        end
    end
endmodule
